// File: rtl/parity_frame_rx_pkg.sv
// Shared constants for the parity-checked serial frame receiver:
// FSM state encoding and error counter width.
package parity_frame_rx_pkg;
  localparam int ERR_CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DATA   = 2'd1;
  localparam state_t ST_PARITY = 2'd2;
  localparam state_t ST_STOP   = 2'd3;
endpackage

// File: rtl/parity_frame_rx.sv
// Strobe-driven serial frame receiver: start, DATA_W bits MSB first, parity, stop.
// Reports good/parity-bad/stop-bad frames as one-cycle pulses and keeps a saturating error count.
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter bit ODD_PAR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 serial_in,
  input  logic                 clr_cnt,
  output logic [DATA_W-1:0]    data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   par_q, par_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   fv_q, fv_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [DATA_W:0]        shift_ext;
  logic                   calc_par;
  logic                   err_ev;

  assign shift_ext = {shift_q, serial_in};
  assign calc_par  = (^shift_q) ^ ODD_PAR;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    fv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!serial_in) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d = shift_ext[DATA_W-1:0];
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          par_d   = serial_in;
          state_d = ST_STOP;
        end
        default: begin
          // A bad stop bit dominates: parity is not reported on a broken frame.
          state_d = ST_IDLE;
          if (!serial_in) begin
            fe_d = 1'b1;
          end else if (calc_par != par_q) begin
            pe_d = 1'b1;
          end else begin
            fv_d   = 1'b1;
            data_d = shift_q;
          end
        end
      endcase
    end
  end

  assign err_ev = fe_d | pe_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = ERR_CNT_W'(err_ev);
    end else if (err_ev && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      fv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      fv_q      <= fv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign data_out    = data_q;
  assign frame_valid = fv_q;
  assign parity_err  = pe_q;
  assign frame_err   = fe_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomized and directed bench for parity_frame_rx, checked every cycle against
// a frame-level reference model that collects strobed bits into a queue.
module tb_parity_frame_rx;
  localparam int DW  = 4;
  localparam bit ODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_valid, serial_in, clr_cnt;
  logic [DW-1:0] data_out;
  logic          frame_valid, parity_err, frame_err, busy;
  logic [7:0]    err_cnt;

  parity_frame_rx #(.DATA_W(DW), .ODD_PAR(ODD)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .serial_in(serial_in),
    .clr_cnt(clr_cnt), .data_out(data_out), .frame_valid(frame_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_fv_seen = 0;

  // reference model state
  bit m_in;
  int m_q[$];
  int m_data, m_cnt;
  bit m_fv, m_pe, m_fe;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ones_mod2(input int v);
    int c = 0;
    for (int i = 0; i < DW; i++) c += (v >> i) & 1;
    return c % 2;
  endfunction

  function automatic int good_par(input int v);
    return (ones_mod2(v) + int'(ODD)) % 2;
  endfunction

  function automatic void model_reset();
    m_in = 0; m_q.delete();
    m_data = 0; m_cnt = 0;
    m_fv = 0; m_pe = 0; m_fe = 0;
  endfunction

  function automatic void model_step(input bit bv, input bit sin, input bit clr);
    bit err;
    m_fv = 0; m_pe = 0; m_fe = 0;
    if (bv) begin
      if (!m_in) begin
        if (!sin) begin m_in = 1; m_q.delete(); end
      end else begin
        m_q.push_back(int'(sin));
        if (m_q.size() == DW + 2) begin
          int v = 0;
          for (int i = 0; i < DW; i++) v = v * 2 + m_q[i];
          if (m_q[DW+1] == 0) m_fe = 1;
          else if (m_q[DW] != good_par(v)) m_pe = 1;
          else begin m_fv = 1; m_data = v; end
          m_in = 0;
        end
      end
    end
    err = m_pe | m_fe;
    if (clr) m_cnt = err ? 1 : 0;
    else if (err && m_cnt < 255) m_cnt++;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".data"}, int'(data_out), m_data);
    chk({tag, ".fv"},   int'(frame_valid), int'(m_fv));
    chk({tag, ".pe"},   int'(parity_err), int'(m_pe));
    chk({tag, ".fe"},   int'(frame_err), int'(m_fe));
    chk({tag, ".busy"}, int'(busy), int'(m_in));
    chk({tag, ".cnt"},  int'(err_cnt), m_cnt);
  endtask

  // Called at posedge+1: drive, clock, update model, compare.
  task automatic step(input bit bv, input bit sin, input bit clr);
    bit_valid = bv; serial_in = sin; clr_cnt = clr;
    @(posedge clk);
    model_step(bv, sin, clr);
    #1;
    if (frame_valid) n_fv_seen++;
    check_all("cyc");
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'b0, 1'($urandom % 2), 1'b0);
  endtask

  task automatic send_frame(input int data, input int par, input int stop,
                            input int gmin, input int gmax, input bit clr_stop);
    int bits[$];
    bits.push_back(0);
    for (int i = DW - 1; i >= 0; i--) bits.push_back((data >> i) & 1);
    bits.push_back(par);
    bits.push_back(stop);
    foreach (bits[i]) begin
      gap(int'($urandom_range(gmax, gmin)));
      step(1'b1, 1'(bits[i]), (i == bits.size() - 1) ? clr_stop : 1'b0);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_async");
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int d, fv0;
    model_reset();
    rst_n = 1'b0; bit_valid = 1'b0; serial_in = 1'b1; clr_cnt = 1'b0;
    @(posedge clk); #1;
    check_all("reset");
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);

    // good frame 1011 / parity 1
    send_frame(4'b1011, 1, 1, 0, 0, 1'b0);
    chk("r033.data", int'(data_out), 4'hB);
    chk("r033.fv", int'(frame_valid), 1);
    chk("r033.cnt", int'(err_cnt), 0);

    // 1001 with parity 1 -> parity mismatch, data retained
    send_frame(4'b1001, 1, 1, 0, 1, 1'b0);
    chk("r034.pe", int'(parity_err), 1);
    chk("r034.data", int'(data_out), 4'hB);
    chk("r034.cnt", int'(err_cnt), 1);

    // bad stop bit only
    send_frame(4'b0000, 0, 0, 0, 1, 1'b0);
    chk("r035.fe", int'(frame_err), 1);
    chk("r035.pe", int'(parity_err), 0);
    chk("r035.cnt", int'(err_cnt), 2);
    step(1'b0, 1'b1, 1'b0);

    // all words, one strobe every 3rd cycle
    fv0 = n_fv_seen;
    for (int w = 0; w < 16; w++) begin
      send_frame(w, good_par(w), 1, 2, 2, 1'b0);
      chk("r036.data", int'(data_out), w);
    end
    chk("r036.nfv", n_fv_seen - fv0, 16);
    chk("r036.cnt", int'(err_cnt), 2);

    // abort mid-frame by reset
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    do_reset();
    send_frame(4'b1111, 0, 1, 0, 1, 1'b0);
    chk("r037.data", int'(data_out), 4'hF);
    chk("r037.fv", int'(frame_valid), 1);

    // saturation, then clear coincident with an error
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 258; k++) begin
      d = int'($urandom_range(15, 0));
      if ($urandom % 2) send_frame(d, 1 - good_par(d), 1, 0, 0, 1'b0);
      else send_frame(d, int'($urandom % 2), 0, 0, 0, 1'b0);
    end
    chk("r038.sat", int'(err_cnt), 255);
    send_frame(4'b0101, 1, 1, 0, 0, 1'b1);
    chk("r038.clr", int'(err_cnt), 1);

    // random traffic: back-to-back frames, gaps, idle strobes, occasional clears
    for (int k = 0; k < 250; k++) begin
      int kind = int'($urandom_range(9, 0));
      d = int'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) step(1'b1, 1'b1, 1'b0);
      if ($urandom_range(15, 0) == 0) step(1'b0, 1'b1, 1'b1);
      if (kind == 0) send_frame(d, int'($urandom % 2), 0, 0, 3, 1'($urandom % 2));
      else if (kind == 1) send_frame(d, 1 - good_par(d), 1, 0, 3, 1'b0);
      else send_frame(d, good_par(d), 1, 0, int'($urandom_range(3, 0)), 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
